pixel_window_fetcher: RTL

- Consumer end of the text pixel generator's toggle interface. It drives toggle_restart and toggle_next, then samples cur_pixels and cur_char after a fixed latency.
- It extracts one 8-pixel-high strip window of WINDOW_COLS vertical pixel columns from the 128x64 text raster.
- It streams the window out as bytes over a valid/ready interface to the Scroll Hat Mini LED driver frame writer.
- Sits between the text pixel generator and the I2C/LED frame writer, same clock domain as the generator.

---
 rtl/pixel_window_fetcher.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pixel_window_fetcher.sv
// Fetches one WINDOW_COLS-wide window of an 8-pixel strip from the text pixel
// generator over its toggle interface and streams the columns out on valid/ready.
module pixel_window_fetcher #(
  parameter int WINDOW_COLS  = 17,
  parameter int PIXEL_COLS   = 128,
  parameter int PIXEL_STRIPS = 8,
  parameter int LATENCY      = 4,
  parameter int COL_SZ       = $clog2(WINDOW_COLS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        scroll_strip,
  input  logic [6:0]        scroll_col,
  output logic              busy,
  output logic              done,
  output logic              toggle_restart,
  output logic              toggle_next,
  input  logic [7:0]        cur_pixels,
  input  logic [7:0]        cur_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_pixels,
  output logic [7:0]        out_char,
  output logic [COL_SZ-1:0] out_col,
  output logic              out_last
);

  localparam int SKIP_W = $clog2(PIXEL_COLS * PIXEL_STRIPS);
  localparam int WAIT_W = $clog2(LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LATENCY);
  localparam logic [COL_SZ-1:0] COL_LAST  = COL_SZ'(WINDOW_COLS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, EMIT, DONE} state_e;

  state_e              state_q, state_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;
  logic [COL_SZ-1:0]   emit_q, emit_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                restart_q, restart_d;
  logic                next_q, next_d;
  logic                valid_q, valid_d;
  logic [7:0]          pixels_q, pixels_d;
  logic [7:0]          char_q, char_d;
  logic [COL_SZ-1:0]   col_q, col_d;
  logic                last_q, last_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      skip_q    <= '0;
      emit_q    <= '0;
      wait_q    <= '0;
      restart_q <= 1'b0;
      next_q    <= 1'b0;
      valid_q   <= 1'b0;
      pixels_q  <= '0;
      char_q    <= '0;
      col_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      emit_q    <= emit_d;
      wait_q    <= wait_d;
      restart_q <= restart_d;
      next_q    <= next_d;
      valid_q   <= valid_d;
      pixels_q  <= pixels_d;
      char_q    <= char_d;
      col_q     <= col_d;
      last_q    <= last_d;
    end
  end

  // Every toggle is followed by a full LATENCY+1 cycle WAIT before the generator
  // output is trusted, whether we are skipping ahead or capturing a column.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    emit_d    = emit_q;
    wait_d    = wait_q;
    restart_d = restart_q;
    next_d    = next_q;
    valid_d   = valid_q;
    pixels_d  = pixels_q;
    char_d    = char_q;
    col_d     = col_q;
    last_d    = last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          skip_d    = SKIP_W'(scroll_strip) * SKIP_W'(PIXEL_COLS) + SKIP_W'(scroll_col);
          emit_d    = '0;
          wait_d    = '0;
          restart_d = ~restart_q;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (wait_q != WAIT_LAST) begin
          wait_d = wait_q + 1'b1;
        end else begin
          wait_d = '0;
          if (skip_q != '0) begin
            skip_d = skip_q - 1'b1;
            next_d = ~next_q;
          end else begin
            pixels_d = cur_pixels;
            char_d   = cur_char;
            col_d    = emit_q;
            last_d   = (emit_q == COL_LAST);
            valid_d  = 1'b1;
            state_d  = EMIT;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = DONE;
          end else begin
            emit_d  = emit_q + 1'b1;
            next_d  = ~next_q;
            wait_d  = '0;
            state_d = WAIT;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy           = (state_q == WAIT) || (state_q == EMIT);
  assign done           = (state_q == DONE);
  assign toggle_restart = restart_q;
  assign toggle_next    = next_q;
  assign out_valid      = valid_q;
  assign out_pixels     = pixels_q;
  assign out_char       = char_q;
  assign out_col        = col_q;
  assign out_last       = last_q;

endmodule
